// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: opcode values, FSM state codes and the
// arithmetic helper that produces the 64-bit {hi,lo} result of an MD opcode.
package md_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BUSY  = 1'b1;

   // wr=0 means the result must not be committed (divide by zero)
   typedef struct packed {
      logic        wr;
      logic [63:0] res;
   } md_res_t;

   // Result layout is {hi, lo}; for divides hi=remainder, lo=quotient
   function automatic md_res_t md_compute(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      md_res_t            r;
      logic signed [63:0] sprod;
      logic [63:0]        uprod;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      r     = '0;
      sa    = $signed(a);
      sb    = $signed(b);
      sq    = '0;
      sr    = '0;
      sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      uprod = {32'd0, a} * {32'd0, b};
      case (op)
         MD_MULT: begin
            r.wr  = 1'b1;
            r.res = sprod;
         end
         MD_MULTU: begin
            r.wr  = 1'b1;
            r.res = uprod;
         end
         MD_DIV: begin
            if (b != 32'd0) begin
               // the one overflowing quotient wraps to itself with no remainder
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  sq = sa;
                  sr = '0;
               end else begin
                  sq = sa / sb;
                  sr = sa % sb;
               end
               r.wr  = 1'b1;
               r.res = {sr, sq};
            end
         end
         MD_DIVU: begin
            if (b != 32'd0) begin
               r.wr  = 1'b1;
               r.res = {a % b, a / b};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/md_if.sv
// E-stage multiply/divide bus: operands and opcode in, HI/LO and hazard
// signals out.
interface md_if;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic [2:0]  md_op;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        start;
   logic        busy;

   modport master (output md_a, md_b, md_op, input hi, lo, start, busy);
   modport slave  (input md_a, md_b, md_op, output hi, lo, start, busy);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit. The result is computed when the operation
// is accepted and held in a pending register; HI/LO only change when the
// busy countdown expires, so the pipeline sees a fixed-latency operation.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   md_if.slave  md
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [63:0]      r_pend;
   logic             r_pend_wr;

   logic             w_start;
   logic             w_is_mul;
   md_res_t          w_res;

   // start is a pure opcode decode so the hazard unit can stall in the same cycle
   assign w_start  = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU) ||
                     (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);
   assign w_is_mul = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
   assign w_res    = md_compute(md.md_op, md.md_a, md.md_b);

   // FSM, countdown and HI/LO: accept in IDLE, commit when the count reaches 1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend    <= '0;
         r_pend_wr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_pend    <= w_res.res;
                  r_pend_wr <= w_res.wr;
                  r_cnt     <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  r_state   <= ST_BUSY;
               end else if (md.md_op == MD_MTHI) begin
                  r_hi <= md.md_a;
               end else if (md.md_op == MD_MTLO) begin
                  r_lo <= md.md_a;
               end
            end
            default: begin
               // opcodes arriving while busy are ignored
               if (r_cnt == CNT_W'(1)) begin
                  if (r_pend_wr) begin
                     r_hi <= r_pend[63:32];
                     r_lo <= r_pend[31:0];
                  end
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign md.start = w_start;
   assign md.busy  = (r_state == ST_BUSY);
   assign md.hi    = r_hi;
   assign md.lo    = r_lo;

endmodule
